// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch and the MEM stage,
// one transaction at a time, data first with a streak limit so fetch cannot starve forever.
module mem_port_arbiter #(
   parameter int unsigned MAX_DATA_STREAK = 4
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_gnt_o,
   output logic        if_rvalid_o,
   output logic [31:0] if_rdata_o,
   input  logic        dm_req_i,
   input  logic        dm_we_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_wdata_i,
   input  logic [3:0]  dm_be_i,
   output logic        dm_gnt_o,
   output logic        dm_rvalid_o,
   output logic [31:0] dm_rdata_o,
   input  logic        flush_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_be_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
   localparam logic [3:0] MAX_S = 4'(MAX_DATA_STREAK);
   state_t      state_q, state_d;
   logic        owner_q, owner_d;
   logic        drop_q, drop_d;
   logic [3:0]  streak_q, streak_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        dm_win, if_win, rsp;
   // owner: 1 = fetch, 0 = data; grants are held off while reset is asserted
   always_comb begin
      dm_win   = rstn_i && state_q == S_IDLE && dm_req_i && (streak_q < MAX_S || !if_req_i || flush_i);
      if_win   = rstn_i && state_q == S_IDLE && !dm_win && if_req_i && !flush_i;
      rsp      = state_q == S_WAIT && mem_rvalid_i;
      state_d  = state_q;
      owner_d  = owner_q;
      drop_d   = drop_q;
      streak_d = streak_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      case (state_q)
         S_IDLE:  state_d = (dm_win || if_win) ? S_REQ : S_IDLE;
         S_REQ:   state_d = mem_gnt_i ? S_WAIT : S_REQ;
         S_WAIT:  state_d = mem_rvalid_i ? S_IDLE : S_WAIT;
         default: state_d = S_IDLE;
      endcase
      if (dm_win) begin
         owner_d  = 1'b0;
         we_d     = dm_we_i;
         addr_d   = dm_addr_i;
         wdata_d  = dm_wdata_i;
         be_d     = dm_be_i;
         streak_d = !if_req_i ? 4'd0 : (streak_q >= MAX_S ? MAX_S : streak_q + 4'd1);
      end else if (if_win) begin
         owner_d  = 1'b1;
         we_d     = 1'b0;
         addr_d   = if_addr_i;
         wdata_d  = 32'd0;
         be_d     = 4'hF;
         streak_d = 4'd0;
      end
      if (state_q != S_IDLE && owner_q && flush_i) drop_d = 1'b1;
      if (state_d == S_IDLE) drop_d = 1'b0;
   end
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q  <= S_IDLE;
         owner_q  <= 1'b0;
         drop_q   <= 1'b0;
         streak_q <= 4'd0;
         we_q     <= 1'b0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         be_q     <= 4'd0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         drop_q   <= drop_d;
         streak_q <= streak_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
      end
   end
   // a fetch response is also killed by a flush arriving in the same cycle as the data
   assign if_gnt_o    = if_win;
   assign dm_gnt_o    = dm_win;
   assign if_rvalid_o = rsp && owner_q && !drop_q && !flush_i;
   assign dm_rvalid_o = rsp && !owner_q;
   assign if_rdata_o  = mem_rdata_i;
   assign dm_rdata_o  = mem_rdata_i;
   assign mem_req_o   = state_q == S_REQ;
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign mem_be_o    = be_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: cycle table for the directed scenarios, a scoreboarded memory model
// for the starvation bound, and a stalled-memory sequence ending in an asynchronous reset.
module tb_mem_port_arbiter;
   localparam logic H = 1'b1, L = 1'b0;
   logic        clk_i = 1'b0, rstn_i = 1'b0;
   logic        if_req_i = 1'b0, dm_req_i = 1'b0, dm_we_i = 1'b0, flush_i = 1'b0;
   logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
   logic [31:0] if_addr_i = '0, dm_addr_i = '0, dm_wdata_i = '0, mem_rdata_i = '0;
   logic [3:0]  dm_be_i = '0;
   logic        if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o, mem_req_o, mem_we_o;
   logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_be_o;
   int n_chk = 0, n_fail = 0;

   mem_port_arbiter dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
      .dm_be_i(dm_be_i), .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
      .flush_i(flush_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        if_req;
      logic [31:0] if_addr;
      logic        dm_req;
      logic        dm_we;
      logic [31:0] dm_addr;
      logic [31:0] dm_wdata;
      logic [3:0]  dm_be;
      logic        flush;
      logic        mem_gnt;
      logic        mem_rvalid;
      logic [31:0] mem_rdata;
      logic        e_if_gnt;
      logic        e_dm_gnt;
      logic        e_if_rv;
      logic        e_dm_rv;
      logic        e_mreq;
      logic        e_mwe;
      logic [31:0] e_maddr;
      logic [31:0] e_mwdata;
      logic [3:0]  e_mbe;
   } vec_t;

   typedef struct {
      logic        own;
      logic [31:0] addr;
   } exp_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " if_gnt"}, 32'(if_gnt_o), 32'd0);
      chk({tag, " dm_gnt"}, 32'(dm_gnt_o), 32'd0);
      chk({tag, " if_rvalid"}, 32'(if_rvalid_o), 32'd0);
      chk({tag, " dm_rvalid"}, 32'(dm_rvalid_o), 32'd0);
      chk({tag, " mem_req"}, 32'(mem_req_o), 32'd0);
      chk({tag, " mem_we"}, 32'(mem_we_o), 32'd0);
      chk({tag, " mem_addr"}, mem_addr_o, 32'd0);
      chk({tag, " mem_wdata"}, mem_wdata_o, 32'd0);
      chk({tag, " mem_be"}, 32'(mem_be_o), 32'd0);
   endtask

   task automatic apply(input int idx, input vec_t v);
      string p;
      p = $sformatf("row%0d", idx);
      if_req_i = v.if_req; if_addr_i = v.if_addr; dm_req_i = v.dm_req; dm_we_i = v.dm_we;
      dm_addr_i = v.dm_addr; dm_wdata_i = v.dm_wdata; dm_be_i = v.dm_be; flush_i = v.flush;
      mem_gnt_i = v.mem_gnt; mem_rvalid_i = v.mem_rvalid; mem_rdata_i = v.mem_rdata;
      #2;
      chk({p, " if_gnt"}, 32'(if_gnt_o), 32'(v.e_if_gnt));
      chk({p, " dm_gnt"}, 32'(dm_gnt_o), 32'(v.e_dm_gnt));
      chk({p, " if_rvalid"}, 32'(if_rvalid_o), 32'(v.e_if_rv));
      chk({p, " dm_rvalid"}, 32'(dm_rvalid_o), 32'(v.e_dm_rv));
      chk({p, " mem_req"}, 32'(mem_req_o), 32'(v.e_mreq));
      chk({p, " mem_we"}, 32'(mem_we_o), 32'(v.e_mwe));
      chk({p, " mem_addr"}, mem_addr_o, v.e_maddr);
      chk({p, " mem_wdata"}, mem_wdata_o, v.e_mwdata);
      chk({p, " mem_be"}, 32'(mem_be_o), 32'(v.e_mbe));
      chk({p, " if_rdata"}, if_rdata_o, v.mem_rdata);
      chk({p, " dm_rdata"}, dm_rdata_o, v.mem_rdata);
      @(posedge clk_i); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[21];
      exp_t        rsp_q[$];
      logic        gnt_q[$];
      exp_t        e;
      logic        exp_own, rv_pend, nxt;
      logic [31:0] mem_lat, if_a, dm_a;
      // columns: if_req if_addr dm_req dm_we dm_addr dm_wdata dm_be flush mem_gnt mem_rvalid mem_rdata | if_gnt dm_gnt if_rv dm_rv mreq mwe maddr mwdata mbe
      tbl[0]  = '{H, 32'h100, L, L, 32'h0, 32'h0, 4'h0, L, L, L, 32'h0,         H, L, L, L, L, L, 32'h0, 32'h0, 4'h0};
      tbl[1]  = '{L, 32'h100, L, L, 32'h0, 32'h0, 4'h0, L, H, L, 32'h0,         L, L, L, L, H, L, 32'h100, 32'h0, 4'hF};
      tbl[2]  = '{L, 32'h100, L, L, 32'h0, 32'h0, 4'h0, L, L, H, 32'h00500093,  L, L, H, L, L, L, 32'h100, 32'h0, 4'hF};
      tbl[3]  = '{L, 32'h0,   L, L, 32'h0, 32'h0, 4'h0, L, L, L, 32'h0,         L, L, L, L, L, L, 32'h100, 32'h0, 4'hF};
      tbl[4]  = '{H, 32'h200, H, H, 32'h2000, 32'hDEADBEEF, 4'hF, L, L, L, 32'h0, L, H, L, L, L, L, 32'h100, 32'h0, 4'hF};
      tbl[5]  = '{H, 32'h200, L, L, 32'h0, 32'h0, 4'h0, L, H, L, 32'h0,         L, L, L, L, H, H, 32'h2000, 32'hDEADBEEF, 4'hF};
      tbl[6]  = '{H, 32'h200, L, L, 32'h0, 32'h0, 4'h0, L, L, H, 32'h0,         L, L, L, H, L, H, 32'h2000, 32'hDEADBEEF, 4'hF};
      tbl[7]  = '{H, 32'h200, L, L, 32'h0, 32'h0, 4'h0, L, L, L, 32'h0,         H, L, L, L, L, H, 32'h2000, 32'hDEADBEEF, 4'hF};
      tbl[8]  = '{L, 32'h200, L, L, 32'h0, 32'h0, 4'h0, L, H, L, 32'h0,         L, L, L, L, H, L, 32'h200, 32'h0, 4'hF};
      tbl[9]  = '{L, 32'h0,   L, L, 32'h0, 32'h0, 4'h0, L, L, H, 32'h12345678,  L, L, H, L, L, L, 32'h200, 32'h0, 4'hF};
      tbl[10] = '{H, 32'h300, L, L, 32'h0, 32'h0, 4'h0, H, L, L, 32'h0,         L, L, L, L, L, L, 32'h200, 32'h0, 4'hF};
      tbl[11] = '{L, 32'h300, L, L, 32'h0, 32'h0, 4'h0, L, L, L, 32'h0,         L, L, L, L, L, L, 32'h200, 32'h0, 4'hF};
      tbl[12] = '{H, 32'h104, L, L, 32'h0, 32'h0, 4'h0, L, L, L, 32'h0,         H, L, L, L, L, L, 32'h200, 32'h0, 4'hF};
      tbl[13] = '{L, 32'h104, L, L, 32'h0, 32'h0, 4'h0, L, H, L, 32'h0,         L, L, L, L, H, L, 32'h104, 32'h0, 4'hF};
      tbl[14] = '{L, 32'h0,   L, L, 32'h0, 32'h0, 4'h0, H, L, L, 32'h0,         L, L, L, L, L, L, 32'h104, 32'h0, 4'hF};
      tbl[15] = '{L, 32'h0,   L, L, 32'h0, 32'h0, 4'h0, L, L, H, 32'hCAFEF00D,  L, L, L, L, L, L, 32'h104, 32'h0, 4'hF};
      tbl[16] = '{L, 32'h0,   H, L, 32'h40, 32'h0, 4'hF, L, L, L, 32'h0,        L, H, L, L, L, L, 32'h104, 32'h0, 4'hF};
      tbl[17] = '{L, 32'h0,   L, L, 32'h0, 32'h0, 4'h0, L, H, L, 32'h0,         L, L, L, L, H, L, 32'h40, 32'h0, 4'hF};
      tbl[18] = '{L, 32'h0,   L, L, 32'h0, 32'h0, 4'h0, L, H, L, 32'h0,         L, L, L, L, L, L, 32'h40, 32'h0, 4'hF};
      tbl[19] = '{L, 32'h0,   L, L, 32'h0, 32'h0, 4'h0, H, L, H, 32'hA5A5A5A5,  L, L, L, H, L, L, 32'h40, 32'h0, 4'hF};
      tbl[20] = '{L, 32'h0,   L, L, 32'h0, 32'h0, 4'h0, L, L, H, 32'h11111111,  L, L, L, L, L, L, 32'h40, 32'h0, 4'hF};

      // reset state, with both requesters active to show grants are held off
      if_req_i = 1'b1; dm_req_i = 1'b1;
      #3 chk_reset("reset");
      @(posedge clk_i); @(posedge clk_i); #1;
      if_req_i = 1'b0; dm_req_i = 1'b0; rstn_i = 1'b1;
      @(posedge clk_i); #1;

      for (int i = 0; i < 21; i++) apply(i, tbl[i]);

      // starvation bound: both sides request continuously, memory grants and answers at once
      for (int k = 0; k < 10; k++) gnt_q.push_back(k % 5 == 4);
      rv_pend = 1'b0; mem_lat = '0; if_a = 32'h8000; dm_a = 32'h1000;
      for (int c = 0; c < 60 && (gnt_q.size() != 0 || rsp_q.size() != 0); c++) begin
         if_req_i = gnt_q.size() != 0; dm_req_i = gnt_q.size() != 0;
         if_addr_i = if_a; dm_addr_i = dm_a; dm_we_i = 1'b0; dm_be_i = 4'hF; dm_wdata_i = '0; flush_i = 1'b0;
         mem_gnt_i = mem_req_o; mem_rvalid_i = rv_pend; mem_rdata_i = rv_pend ? mem_lat : 32'h0;
         #2;
         if (mem_req_o && rsp_q.size() != 0) chk("sb mem_addr", mem_addr_o, rsp_q[0].addr);
         if ((if_gnt_o || dm_gnt_o) && gnt_q.size() != 0) begin
            exp_own = gnt_q.pop_front();
            chk("sb grant is fetch", 32'(if_gnt_o), 32'(exp_own));
            chk("sb single grant", 32'(if_gnt_o & dm_gnt_o), 32'd0);
            rsp_q.push_back('{exp_own, exp_own ? if_a : dm_a});
            if (exp_own) if_a += 32'd4; else dm_a += 32'd4;
         end
         if ((if_rvalid_o || dm_rvalid_o) && rsp_q.size() != 0) begin
            e = rsp_q.pop_front();
            chk("sb rvalid is fetch", 32'(if_rvalid_o), 32'(e.own));
            chk("sb rdata", e.own ? if_rdata_o : dm_rdata_o, ~e.addr);
         end
         nxt = mem_req_o && mem_gnt_i;
         if (nxt) mem_lat = ~mem_addr_o;
         @(posedge clk_i); #1;
         rv_pend = nxt;
      end
      n_chk++;
      if (gnt_q.size() != 0 || rsp_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb drain: got %0d grants and %0d responses outstanding, expected 0", gnt_q.size(), rsp_q.size());
      end

      // stalled memory, then asynchronous reset while the request is pending
      if_req_i = 1'b0; dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h3000; dm_wdata_i = 32'h55AA55AA;
      dm_be_i = 4'h3; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      #2 chk("stall dm_gnt", 32'(dm_gnt_o), 32'd1);
      @(posedge clk_i); #1;
      dm_req_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #2;
         chk("stall mem_req", 32'(mem_req_o), 32'd1);
         chk("stall mem_addr", mem_addr_o, 32'h3000);
         chk("stall mem_wdata", mem_wdata_o, 32'h55AA55AA);
         chk("stall mem_be", 32'(mem_be_o), 32'h3);
         chk("stall mem_we", 32'(mem_we_o), 32'd1);
         @(posedge clk_i); #1;
      end
      if_req_i = 1'b1; dm_req_i = 1'b1; rstn_i = 1'b0;
      #1 chk_reset("async reset");
      @(posedge clk_i); #1;
      chk_reset("held reset");
      if_req_i = 1'b0; dm_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77777777; rstn_i = 1'b1;
      #2;
      chk("late rsp if_rvalid", 32'(if_rvalid_o), 32'd0);
      chk("late rsp dm_rvalid", 32'(dm_rvalid_o), 32'd0);
      @(posedge clk_i); #1;
      mem_rvalid_i = 1'b0;
      #2 chk("post reset mem_req", 32'(mem_req_o), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported unified memory between the fetch stage (instruction reads) and the MEM stage (loads and stores) of the five-stage pipeline. The block runs one memory transaction at a time using a three-state FSM. Data accesses have priority over fetches, and a streak counter bounds how long fetch can be starved. A taken branch flushes the fetch path: the response of an in-flight fetch is discarded and a same-cycle fetch request is refused.

## Interface
- Parameter `MAX_DATA_STREAK`, default 4: consecutive data grants allowed while fetch is waiting; legal range 1..15.
- `clk_i` input, 1 bit: the single clock; all state updates on its rising edge.
- `rstn_i` input, 1 bit: reset, asynchronous and active-low.
- `if_req_i` input, 1 bit: fetch request; `if_addr_i` is held stable until `if_gnt_o`.
- `if_addr_i` input, 32 bits: fetch address (word aligned).
- `if_gnt_o` output, 1 bit: fetch request accepted this cycle.
- `if_rvalid_o` output, 1 bit: fetch data valid.
- `if_rdata_o` output, 32 bits: fetched instruction.
- `dm_req_i` input, 1 bit: data request; all data-side inputs are held stable until `dm_gnt_o`.
- `dm_we_i` input, 1 bit: 1 = store, 0 = load.
- `dm_addr_i` input, 32 bits: data address.
- `dm_wdata_i` input, 32 bits: store data.
- `dm_be_i` input, 4 bits: store byte enables.
- `dm_gnt_o` output, 1 bit: data request accepted this cycle.
- `dm_rvalid_o` output, 1 bit: load data valid, or store completion.
- `dm_rdata_o` output, 32 bits: load data.
- `flush_i` input, 1 bit: branch taken; kill the fetch path.
- `mem_req_o` output, 1 bit: memory request.
- `mem_we_o` output, 1 bit: memory write enable.
- `mem_addr_o` output, 32 bits: memory address.
- `mem_wdata_o` output, 32 bits: memory write data.
- `mem_be_o` output, 4 bits: memory byte enables.
- `mem_gnt_i` input, 1 bit: memory accepted the request.
- `mem_rvalid_i` input, 1 bit: memory response valid; arrives at least 1 cycle after `mem_gnt_i`.
- `mem_rdata_i` input, 32 bits: memory read data.

## Operation
- **FSM states.**
  - IDLE: accepts a new request.
  - REQ: `mem_req_o` = 1, waiting for `mem_gnt_i`.
  - WAIT: waiting for `mem_rvalid_i`.
- **Selection in IDLE** (combinational, same cycle):
  - If `dm_req_i` = 1 and (`streak` < `MAX_DATA_STREAK` or `if_req_i` = 0 or `flush_i` = 1), data wins.
  - Otherwise, if `if_req_i` = 1 and `flush_i` = 0, fetch wins.
  - Otherwise, no grant.
- **Grant.** The winner's gnt is asserted for exactly one cycle. In that cycle:
  - Address, write enable, write data and byte enables are latched; fetch latches `we` = 0 and `be` = 4'hF.
  - `owner` (IF or DM) is latched.
  - Next state is REQ.
- **Memory outputs.** The `mem_*` outputs are driven from the latched registers. `mem_req_o` = 1 only in REQ. The request is never retracted before `mem_gnt_i`.
- **REQ.** On `mem_gnt_i` go to WAIT; otherwise stay in REQ.
- **WAIT.** On `mem_rvalid_i`:
  - Pass the response through combinationally to the owner: `*_rvalid_o` = 1 and `*_rdata_o` = `mem_rdata_i`.
  - Go to IDLE.
- **Rdata when not valid.** `if_rdata_o` and `dm_rdata_o` show `mem_rdata_i` at all times; they are meaningful only when the matching rvalid = 1.
- **Streak counter** (4 bits, saturating at `MAX_DATA_STREAK`):
  - Increments on a data grant while `if_req_i` = 1.
  - Clears on a data grant while `if_req_i` = 0.
  - Clears on a fetch grant.
- **Flush.**
  - `flush_i` in IDLE blocks the fetch grant that cycle.
  - `flush_i` in REQ or WAIT with `owner` = IF sets a `drop` flag. The memory transaction still completes, but `if_rvalid_o` is suppressed for it. `drop` clears on return to IDLE.
  - `flush_i` never affects a data transaction.
- **Unexpected responses.** `mem_rvalid_i` in IDLE or REQ is ignored. `mem_gnt_i` outside REQ is ignored.

## Timing
- **Reset** (asynchronous, while `rstn_i` = 0):
  - State is IDLE; `owner` = DM; `streak` = 0; `drop` = 0.
  - All latched registers are 0, so `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o` and `mem_be_o` are 0.
  - `if_gnt_o`, `dm_gnt_o`, `if_rvalid_o` and `dm_rvalid_o` are 0.
- **Reset mid-transaction.** The transaction is abandoned and `mem_req_o` drops immediately. Any later `mem_rvalid_i` for it arrives in IDLE and is ignored.
- **Latency.**
  - Request at cycle 0 gives gnt in cycle 0 and `mem_req_o` in cycle 1.
  - With `mem_gnt_i` in cycle 1 and `mem_rvalid_i` in cycle 2, `rvalid_o` is asserted in cycle 2.
  - The next grant is possible in cycle 3.
  - Best-case throughput is one transaction every 3 cycles.
- **gnt outputs** are asserted only in IDLE and never both in the same cycle.
- **rvalid outputs** are asserted only in WAIT and never both in the same cycle.

## Test plan
- **Fetch alone.** `if_req_i` = 1, `if_addr_i` = 0x100; memory grants in cycle 1 and returns 0x00500093 in cycle 2. Expect: `if_gnt_o` in cycle 0; `mem_addr_o` = 0x100 with `mem_we_o` = 0 in cycle 1; `if_rvalid_o` = 1 with `if_rdata_o` = 0x00500093 in cycle 2.
- **Contention.** Both requesters active in the same IDLE cycle; data is a store to 0x2000 with wdata 0xDEADBEEF. Expect: `dm_gnt_o` first, with `mem_we_o` = 1 and `mem_be_o` = 4'hF; fetch granted afterwards.
- **Starvation bound.** `MAX_DATA_STREAK` = 4; `dm_req_i` and `if_req_i` held at 1 continuously. Expect: data grants 1-4, then a fetch grant, then the data streak restarts.
- **Flush during WAIT.** `flush_i` pulsed while a fetch to 0x104 is in WAIT. Expect: `mem_rvalid_i` consumed, `if_rvalid_o` stays 0, FSM returns to IDLE.
- **Flush in IDLE.** `flush_i` and `if_req_i` both 1 in IDLE with `dm_req_i` = 0. Expect: no grant and state remains IDLE.
- **Stalled memory and reset.** `mem_gnt_i` held at 0 for 5 cycles. Expect: `mem_req_o` and address stable throughout. Then assert `rstn_i` = 0 in REQ: `mem_req_o` falls to 0 at once, and the bench checks every output against its reset value.
